// File: rtl/tcs_cmp_slice.sv
// tcs_cmp_slice: two-bit cascadable magnitude comparator slice, gate-level cascade path
// plus registered result copies and a sticky illegal-cascade flag.
module tcs_cmp_slice #(
    parameter int GATE_DELAY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       eq,
    input  logic       gt,
    output logic       EQ,
    output logic       GT,
    output logic       LT,
    output logic       EQ_R,
    output logic       GT_R,
    output logic       LT_R,
    output logic       CASC_ERR
);
    logic nb1, nb0, e1, e0, h1, h0, a_gt, a_eq, t_gt, n_gt, n_big, n_same;
    // The ideal netlist is kept separate so zero-delay builds carry no timing controls.
    generate
        if (GATE_DELAY == 0) begin : g_ideal
            not  u_nb1 (nb1, b[1]);
            not  u_nb0 (nb0, b[0]);
            xnor u_e1  (e1, a[1], b[1]);
            xnor u_e0  (e0, a[0], b[0]);
            and  u_h1  (h1, a[1], nb1);
            and  u_h0  (h0, e1, a[0], nb0);
            or   u_agt (a_gt, h1, h0);
            and  u_aeq (a_eq, e1, e0);
            and  u_tgt (t_gt, eq, a_gt);
            or   u_gt  (GT, gt, t_gt);
            not  u_ngt (n_gt, gt);
            and  u_eq  (EQ, eq, n_gt, a_eq);
            not  u_nbg (n_big, GT);
            not  u_nsm (n_same, EQ);
            and  u_lt  (LT, n_big, n_same);
        end else begin : g_timed
            not  #(GATE_DELAY) u_nb1 (nb1, b[1]);
            not  #(GATE_DELAY) u_nb0 (nb0, b[0]);
            xnor #(GATE_DELAY) u_e1  (e1, a[1], b[1]);
            xnor #(GATE_DELAY) u_e0  (e0, a[0], b[0]);
            and  #(GATE_DELAY) u_h1  (h1, a[1], nb1);
            and  #(GATE_DELAY) u_h0  (h0, e1, a[0], nb0);
            or   #(GATE_DELAY) u_agt (a_gt, h1, h0);
            and  #(GATE_DELAY) u_aeq (a_eq, e1, e0);
            and  #(GATE_DELAY) u_tgt (t_gt, eq, a_gt);
            or   #(GATE_DELAY) u_gt  (GT, gt, t_gt);
            not  #(GATE_DELAY) u_ngt (n_gt, gt);
            and  #(GATE_DELAY) u_eq  (EQ, eq, n_gt, a_eq);
            not  #(GATE_DELAY) u_nbg (n_big, GT);
            not  #(GATE_DELAY) u_nsm (n_same, EQ);
            and  #(GATE_DELAY) u_lt  (LT, n_big, n_same);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            EQ_R     <= 1'b0;
            GT_R     <= 1'b0;
            LT_R     <= 1'b0;
            CASC_ERR <= 1'b0;
        end else begin
            EQ_R     <= EQ;
            GT_R     <= GT;
            LT_R     <= LT;
            CASC_ERR <= CASC_ERR | (eq & gt);
        end
    end
endmodule

// File: tb/tb_tcs_cmp_slice.sv
// tb_tcs_cmp_slice: checks a single slice and a two-slice chain against a value-level
// comparison model, including registered copies, sticky cascade error and async reset.
module tb_tcs_cmp_slice;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] a = 2'b00, b = 2'b00;
    logic       eq = 1'b1, gt = 1'b0;
    logic       EQ, GT, LT, EQ_R, GT_R, LT_R, CASC_ERR;
    logic [3:0] ca = 4'd0, cb = 4'd0;
    logic       h_eq, h_gt, h_lt, h_eqr, h_gtr, h_ltr, h_err;
    logic       l_eq, l_gt, l_lt, l_eqr, l_gtr, l_ltr, l_err;
    int         total = 0, bad = 0;
    logic [2:0] prev_exp;
    logic       prev_ill = 1'b0, have_prev = 1'b0, err_m = 1'b0, in_rst = 1'b0;

    always #5 clk = ~clk;

    tcs_cmp_slice dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .eq(eq), .gt(gt),
        .EQ(EQ), .GT(GT), .LT(LT), .EQ_R(EQ_R), .GT_R(GT_R), .LT_R(LT_R), .CASC_ERR(CASC_ERR)
    );
    tcs_cmp_slice u_hi (
        .clk(clk), .reset(reset), .a(ca[3:2]), .b(cb[3:2]), .eq(1'b1), .gt(1'b0),
        .EQ(h_eq), .GT(h_gt), .LT(h_lt), .EQ_R(h_eqr), .GT_R(h_gtr), .LT_R(h_ltr), .CASC_ERR(h_err)
    );
    tcs_cmp_slice u_lo (
        .clk(clk), .reset(reset), .a(ca[1:0]), .b(cb[1:0]), .eq(h_eq), .gt(h_gt),
        .EQ(l_eq), .GT(l_gt), .LT(l_lt), .EQ_R(l_eqr), .GT_R(l_gtr), .LT_R(l_ltr), .CASC_ERR(l_err)
    );

    // Result as {EQ,GT,LT}: higher slices decide unless they are still equal.
    function automatic logic [2:0] ref_cmp(input logic [1:0] x, input logic [1:0] y,
                                           input logic e, input logic g);
        if (g) return 3'b010;
        if (!e) return 3'b001;
        if (x > y) return 3'b010;
        if (x == y) return 3'b100;
        return 3'b001;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] ai, input logic [1:0] bi, input logic ei, input logic gi);
        logic [2:0] e;
        @(posedge clk);
        #1;
        a = ai; b = bi; eq = ei; gt = gi;
        e = ref_cmp(ai, bi, ei, gi);
        @(negedge clk);
        check("comb", {1'b0, EQ, GT, LT}, {1'b0, e});
        if (in_rst) check("regs_in_reset", {CASC_ERR, EQ_R, GT_R, LT_R}, 4'b0000);
        else if (have_prev) begin
            err_m = err_m | prev_ill;
            check("regs", {CASC_ERR, EQ_R, GT_R, LT_R}, {err_m, prev_exp});
        end
        prev_exp = e; prev_ill = ei & gi; have_prev = 1'b1;
    endtask

    task automatic chain(input logic [3:0] x, input logic [3:0] y);
        logic [2:0] e;
        ca = x; cb = y;
        #1;
        e = (x == y) ? 3'b100 : (x > y) ? 3'b010 : 3'b001;
        check("chain", {1'b0, l_eq, l_gt, l_lt}, {1'b0, e});
    endtask

    task automatic rand_code(output logic e, output logic g);
        int c;
        c = $urandom_range(0, 2);
        e = (c == 0); g = (c == 1);
    endtask

    initial begin
        logic re, rg;
        #2 reset = 1'b0;
        #1 check("reset_state", {CASC_ERR, EQ_R, GT_R, LT_R}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        prev_exp = ref_cmp(a, b, eq, gt); have_prev = 1'b1;
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 16; i++)
                step(i[3:2], i[1:0], c == 0, c == 1);
        step(2'b10, 2'b01, 1'b1, 1'b0);
        step(2'b11, 2'b11, 1'b1, 1'b0);
        step(2'b00, 2'b11, 1'b0, 1'b1);
        step(2'b11, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            rand_code(re, rg);
            step(2'($urandom), 2'($urandom), re, rg);
        end
        chain(4'b1001, 4'b1010);
        chain(4'b0110, 4'b0110);
        for (int i = 0; i < 40; i++) chain(4'($urandom), 4'($urandom));
        step(2'b01, 2'b10, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(2'($urandom), 2'($urandom), 1'b1, 1'b0);
        #1 reset = 1'b0;
        in_rst = 1'b1; err_m = 1'b0; prev_ill = 1'b0;
        #1 check("async_clear", {CASC_ERR, EQ_R, GT_R, LT_R}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            rand_code(re, rg);
            step(2'($urandom), 2'($urandom), re, rg);
        end
        reset = 1'b1;
        in_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_code(re, rg);
            step(2'($urandom), 2'($urandom), re, rg);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
